dispatcher: RTL and testbench

Issue stage of the out-of-order core: it takes one decoded instruction at a time from the decoder and allocates its ROB entry. It resolves the two source operands to value/tag pairs using the register-file rename tags, the ROB ready values and both CDBs. It then sends the entry to the reservation station (ALU ops) or the load/store buffer (memory ops), and renames `rd` in the register file. It is the transmitting end of the RS/LSB insert interface.

---
 rtl/dispatcher_pkg.sv | 36 +++
 rtl/dispatcher_operand_resolver.sv | 46 ++++
 rtl/dispatcher.sv | 273 +++++++++++++++++++++++++++
 tb/tb_dispatcher.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// ============================================================================
// Module      : dispatcher_pkg
// Description : Shared opcode enumeration and constants for the issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dispatcher_pkg;

  localparam int DEF_DATA_LEN   = 32;
  localparam int DEF_ADDR_LEN   = 32;
  localparam int DEF_ROB_LEN    = 4;
  localparam int DEF_OPENUM_LEN = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [DEF_ROB_LEN:0]    ZERO_ROB  = '0;
  localparam logic [DEF_DATA_LEN-1:0] ZERO_WORD = '0;
  localparam logic [DEF_ADDR_LEN-1:0] ZERO_ADDR = '0;

  typedef enum logic [DEF_OPENUM_LEN-1:0] {
    OPENUM_NOP,
    OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
    OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
    OPENUM_LB, OPENUM_LH, OPENUM_LW, OPENUM_LBU, OPENUM_LHU,
    OPENUM_SB, OPENUM_SH, OPENUM_SW,
    OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI, OPENUM_ANDI,
    OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
    OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
    OPENUM_XOR, OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND
  } openum_e;

endpackage

`default_nettype wire

// File: rtl/dispatcher_operand_resolver.sv
// ============================================================================
// Module      : dispatcher_operand_resolver
// Description : Resolves one source tag to value/tag (CDB > ROB ready > regfile).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatcher_operand_resolver #(
  parameter int DATA_LEN = 32,
  parameter int ROB_LEN  = 4
) (
  input  logic [ROB_LEN:0]    i_tag,
  input  logic [DATA_LEN-1:0] i_reg_val,
  input  logic                i_rob_ready,
  input  logic [DATA_LEN-1:0] i_rob_val,
  input  logic                i_rs_cdb_valid,
  input  logic [ROB_LEN:0]    i_rs_cdb_rob_id,
  input  logic [DATA_LEN-1:0] i_rs_cdb_result,
  input  logic                i_ls_cdb_valid,
  input  logic [ROB_LEN:0]    i_ls_cdb_rob_id,
  input  logic [DATA_LEN-1:0] i_ls_cdb_result,
  output logic [DATA_LEN-1:0] o_val,
  output logic [ROB_LEN:0]    o_tag
);

  always_comb begin
    o_val = '0;
    o_tag = i_tag;
    if (i_tag == '0) begin
      o_val = i_reg_val;
      o_tag = '0;
    end else if (i_rs_cdb_valid && (i_rs_cdb_rob_id == i_tag)) begin
      o_val = i_rs_cdb_result;
      o_tag = '0;
    end else if (i_ls_cdb_valid && (i_ls_cdb_rob_id == i_tag)) begin
      o_val = i_ls_cdb_result;
      o_tag = '0;
    end else if (i_rob_ready) begin
      o_val = i_rob_val;
      o_tag = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dispatcher.sv
// ============================================================================
// Module      : dispatcher
// Description : One-entry issue buffer: allocates ROB, resolves operands,
//               inserts into RS or LSB and renames rd.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatcher
  import dispatcher_pkg::*;
#(
  parameter int DATA_LEN   = 32,
  parameter int ADDR_LEN   = 32,
  parameter int OPENUM_LEN = 6,
  parameter int ROB_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rollback,
  input  logic                  valid_from_dec,
  input  logic [OPENUM_LEN-1:0] openum_from_dec,
  input  logic [4:0]            rd_from_dec,
  input  logic [4:0]            rs1_from_dec,
  input  logic [4:0]            rs2_from_dec,
  input  logic [DATA_LEN-1:0]   imm_from_dec,
  input  logic [ADDR_LEN-1:0]   pc_from_dec,
  input  logic                  is_ls_from_dec,
  output logic                  stall_to_dec,
  output logic [4:0]            rs1_to_reg,
  output logic [4:0]            rs2_to_reg,
  input  logic [DATA_LEN-1:0]   V1_from_reg,
  input  logic [DATA_LEN-1:0]   V2_from_reg,
  input  logic [ROB_LEN:0]      Q1_from_reg,
  input  logic [ROB_LEN:0]      Q2_from_reg,
  output logic [ROB_LEN:0]      Q1_to_rob,
  output logic [ROB_LEN:0]      Q2_to_rob,
  input  logic                  ready1_from_rob,
  input  logic                  ready2_from_rob,
  input  logic [DATA_LEN-1:0]   val1_from_rob,
  input  logic [DATA_LEN-1:0]   val2_from_rob,
  input  logic [ROB_LEN:0]      rob_id_from_rob,
  input  logic                  full_from_rob,
  input  logic                  full_from_rs,
  input  logic                  full_from_lsb,
  output logic                  ena_to_rob,
  output logic                  ena_to_rs,
  output logic                  ena_to_lsb,
  output logic [OPENUM_LEN-1:0] openum_to_rs,
  output logic [DATA_LEN-1:0]   V1_to_rs,
  output logic [DATA_LEN-1:0]   V2_to_rs,
  output logic [ROB_LEN:0]      Q1_to_rs,
  output logic [ROB_LEN:0]      Q2_to_rs,
  output logic [ADDR_LEN-1:0]   pc_to_rs,
  output logic [DATA_LEN-1:0]   imm_to_rs,
  output logic [ROB_LEN:0]      rob_id_to_rs,
  output logic [OPENUM_LEN-1:0] openum_to_lsb,
  output logic [DATA_LEN-1:0]   V1_to_lsb,
  output logic [DATA_LEN-1:0]   V2_to_lsb,
  output logic [ROB_LEN:0]      Q1_to_lsb,
  output logic [ROB_LEN:0]      Q2_to_lsb,
  output logic [ADDR_LEN-1:0]   pc_to_lsb,
  output logic [DATA_LEN-1:0]   imm_to_lsb,
  output logic [ROB_LEN:0]      rob_id_to_lsb,
  output logic [4:0]            rd_to_rob,
  output logic                  ena_rename_to_reg,
  output logic [4:0]            rd_to_reg,
  output logic [ROB_LEN:0]      rob_id_to_reg,
  input  logic                  valid_from_rs_cdb,
  input  logic [ROB_LEN:0]      rob_id_from_rs_cdb,
  input  logic [DATA_LEN-1:0]   result_from_rs_cdb,
  input  logic                  valid_from_ls_cdb,
  input  logic [ROB_LEN:0]      rob_id_from_ls_cdb,
  input  logic [DATA_LEN-1:0]   result_from_ls_cdb
);

  localparam logic [OPENUM_LEN-1:0] c_nop = OPENUM_LEN'(OPENUM_NOP);

  // Holding buffer
  logic                  r_busy;
  logic [OPENUM_LEN-1:0] r_buf_openum;
  logic [4:0]            r_buf_rd;
  logic [DATA_LEN-1:0]   r_buf_imm;
  logic [ADDR_LEN-1:0]   r_buf_pc;
  logic                  r_buf_is_ls;
  logic [DATA_LEN-1:0]   r_buf_v [2];
  logic [ROB_LEN:0]      r_buf_q [2];

  // Registered insert bus and strobes
  logic                  r_ena_rob;
  logic                  r_ena_rs;
  logic                  r_ena_lsb;
  logic                  r_ena_rename;
  logic [OPENUM_LEN-1:0] r_openum;
  logic [DATA_LEN-1:0]   r_v1;
  logic [DATA_LEN-1:0]   r_v2;
  logic [ROB_LEN:0]      r_q1;
  logic [ROB_LEN:0]      r_q2;
  logic [ADDR_LEN-1:0]   r_pc;
  logic [DATA_LEN-1:0]   r_imm;
  logic [ROB_LEN:0]      r_rob_id;
  logic [4:0]            r_rd;

  logic                  w_issue;
  logic                  w_accept;
  logic [ROB_LEN:0]      w_dec_q   [2];
  logic [DATA_LEN-1:0]   w_dec_v   [2];
  logic                  w_rob_rdy [2];
  logic [DATA_LEN-1:0]   w_rob_val [2];
  logic [DATA_LEN-1:0]   w_acc_v   [2];
  logic [ROB_LEN:0]      w_acc_q   [2];
  logic [DATA_LEN-1:0]   w_snp_v   [2];
  logic [ROB_LEN:0]      w_snp_q   [2];

  assign w_dec_q[0]   = Q1_from_reg;
  assign w_dec_q[1]   = Q2_from_reg;
  assign w_dec_v[0]   = V1_from_reg;
  assign w_dec_v[1]   = V2_from_reg;
  assign w_rob_rdy[0] = ready1_from_rob;
  assign w_rob_rdy[1] = ready2_from_rob;
  assign w_rob_val[0] = val1_from_rob;
  assign w_rob_val[1] = val2_from_rob;

  // Accept path resolves fresh decoder operands; snoop path keeps the buffered
  // operands current, so a same-cycle issue already carries this cycle's CDB.
  for (genvar i = 0; i < 2; i++) begin : g_opnd
    dispatcher_operand_resolver #(
      .DATA_LEN (DATA_LEN),
      .ROB_LEN  (ROB_LEN)
    ) u_accept (
      .i_tag           (w_dec_q[i]),
      .i_reg_val       (w_dec_v[i]),
      .i_rob_ready     (w_rob_rdy[i]),
      .i_rob_val       (w_rob_val[i]),
      .i_rs_cdb_valid  (valid_from_rs_cdb),
      .i_rs_cdb_rob_id (rob_id_from_rs_cdb),
      .i_rs_cdb_result (result_from_rs_cdb),
      .i_ls_cdb_valid  (valid_from_ls_cdb),
      .i_ls_cdb_rob_id (rob_id_from_ls_cdb),
      .i_ls_cdb_result (result_from_ls_cdb),
      .o_val           (w_acc_v[i]),
      .o_tag           (w_acc_q[i])
    );

    dispatcher_operand_resolver #(
      .DATA_LEN (DATA_LEN),
      .ROB_LEN  (ROB_LEN)
    ) u_snoop (
      .i_tag           (r_buf_q[i]),
      .i_reg_val       (r_buf_v[i]),
      .i_rob_ready     (FALSE),
      .i_rob_val       ('0),
      .i_rs_cdb_valid  (valid_from_rs_cdb),
      .i_rs_cdb_rob_id (rob_id_from_rs_cdb),
      .i_rs_cdb_result (result_from_rs_cdb),
      .i_ls_cdb_valid  (valid_from_ls_cdb),
      .i_ls_cdb_rob_id (rob_id_from_ls_cdb),
      .i_ls_cdb_result (result_from_ls_cdb),
      .o_val           (w_snp_v[i]),
      .o_tag           (w_snp_q[i])
    );
  end

  assign w_issue  = r_busy && !full_from_rob &&
                    (r_buf_is_ls ? !full_from_lsb : !full_from_rs);
  assign w_accept = valid_from_dec && !stall_to_dec;

  assign stall_to_dec = r_busy && !w_issue;
  assign rs1_to_reg   = rs1_from_dec;
  assign rs2_to_reg   = rs2_from_dec;
  assign Q1_to_rob    = Q1_from_reg;
  assign Q2_to_rob    = Q2_from_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= FALSE;
      r_buf_openum <= c_nop;
      r_buf_rd     <= '0;
      r_buf_imm    <= '0;
      r_buf_pc     <= '0;
      r_buf_is_ls  <= FALSE;
      for (int i = 0; i < 2; i++) begin
        r_buf_v[i] <= '0;
        r_buf_q[i] <= '0;
      end
      r_ena_rob    <= FALSE;
      r_ena_rs     <= FALSE;
      r_ena_lsb    <= FALSE;
      r_ena_rename <= FALSE;
      r_openum     <= c_nop;
      r_v1         <= '0;
      r_v2         <= '0;
      r_q1         <= '0;
      r_q2         <= '0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_rob_id     <= '0;
      r_rd         <= '0;
    end else begin
      r_ena_rob    <= FALSE;
      r_ena_rs     <= FALSE;
      r_ena_lsb    <= FALSE;
      r_ena_rename <= FALSE;
      if (rollback) begin
        r_busy <= FALSE;
      end else begin
        if (w_issue) begin
          r_ena_rob    <= TRUE;
          r_ena_rs     <= !r_buf_is_ls;
          r_ena_lsb    <= r_buf_is_ls;
          r_ena_rename <= (r_buf_rd != 5'd0);
          r_openum     <= r_buf_openum;
          r_v1         <= w_snp_v[0];
          r_q1         <= w_snp_q[0];
          r_v2         <= w_snp_v[1];
          r_q2         <= w_snp_q[1];
          r_pc         <= r_buf_pc;
          r_imm        <= r_buf_imm;
          r_rob_id     <= rob_id_from_rob;
          r_rd         <= r_buf_rd;
        end
        if (w_accept) begin
          r_busy       <= TRUE;
          r_buf_openum <= openum_from_dec;
          r_buf_rd     <= rd_from_dec;
          r_buf_imm    <= imm_from_dec;
          r_buf_pc     <= pc_from_dec;
          r_buf_is_ls  <= is_ls_from_dec;
          for (int i = 0; i < 2; i++) begin
            r_buf_v[i] <= w_acc_v[i];
            r_buf_q[i] <= w_acc_q[i];
          end
        end else if (w_issue) begin
          r_busy <= FALSE;
        end else if (r_busy) begin
          for (int i = 0; i < 2; i++) begin
            r_buf_v[i] <= w_snp_v[i];
            r_buf_q[i] <= w_snp_q[i];
          end
        end
      end
    end
  end

  assign ena_to_rob        = r_ena_rob;
  assign ena_to_rs         = r_ena_rs;
  assign ena_to_lsb        = r_ena_lsb;
  assign ena_rename_to_reg = r_ena_rename;

  assign openum_to_rs  = r_openum;
  assign V1_to_rs      = r_v1;
  assign V2_to_rs      = r_v2;
  assign Q1_to_rs      = r_q1;
  assign Q2_to_rs      = r_q2;
  assign pc_to_rs      = r_pc;
  assign imm_to_rs     = r_imm;
  assign rob_id_to_rs  = r_rob_id;

  assign openum_to_lsb = r_openum;
  assign V1_to_lsb     = r_v1;
  assign V2_to_lsb     = r_v2;
  assign Q1_to_lsb     = r_q1;
  assign Q2_to_lsb     = r_q2;
  assign pc_to_lsb     = r_pc;
  assign imm_to_lsb    = r_imm;
  assign rob_id_to_lsb = r_rob_id;

  assign rd_to_rob     = r_rd;
  assign rd_to_reg     = r_rd;
  assign rob_id_to_reg = r_rob_id;

endmodule

`default_nettype wire

// File: tb/tb_dispatcher.sv
// ============================================================================
// Module      : tb_dispatcher
// Description : Scoreboard bench for the dispatcher issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dispatcher;
  import dispatcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rollback, valid_from_dec;
  logic [5:0]  openum_from_dec;
  logic [4:0]  rd_from_dec, rs1_from_dec, rs2_from_dec;
  logic [31:0] imm_from_dec, pc_from_dec;
  logic        is_ls_from_dec;
  logic        stall_to_dec;
  logic [4:0]  rs1_to_reg, rs2_to_reg;
  logic [31:0] V1_from_reg, V2_from_reg;
  logic [4:0]  Q1_from_reg, Q2_from_reg, Q1_to_rob, Q2_to_rob;
  logic        ready1_from_rob, ready2_from_rob;
  logic [31:0] val1_from_rob, val2_from_rob;
  logic [4:0]  rob_id_from_rob;
  logic        full_from_rob, full_from_rs, full_from_lsb;
  logic        ena_to_rob, ena_to_rs, ena_to_lsb;
  logic [5:0]  openum_to_rs, openum_to_lsb;
  logic [31:0] V1_to_rs, V2_to_rs, V1_to_lsb, V2_to_lsb;
  logic [4:0]  Q1_to_rs, Q2_to_rs, Q1_to_lsb, Q2_to_lsb;
  logic [31:0] pc_to_rs, imm_to_rs, pc_to_lsb, imm_to_lsb;
  logic [4:0]  rob_id_to_rs, rob_id_to_lsb, rd_to_rob;
  logic        ena_rename_to_reg;
  logic [4:0]  rd_to_reg, rob_id_to_reg;
  logic        valid_from_rs_cdb, valid_from_ls_cdb;
  logic [4:0]  rob_id_from_rs_cdb, rob_id_from_ls_cdb;
  logic [31:0] result_from_rs_cdb, result_from_ls_cdb;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] v1, v2;
    logic [4:0]  q1, q2;
    logic [31:0] imm, pc;
    logic [4:0]  rob, rd;
    logic        is_ls;
  } exp_t;

  exp_t sb[$];
  exp_t r_exp;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dispatcher u_dut (
    .clk(clk), .rst(rst), .rollback(rollback),
    .valid_from_dec(valid_from_dec), .openum_from_dec(openum_from_dec),
    .rd_from_dec(rd_from_dec), .rs1_from_dec(rs1_from_dec), .rs2_from_dec(rs2_from_dec),
    .imm_from_dec(imm_from_dec), .pc_from_dec(pc_from_dec), .is_ls_from_dec(is_ls_from_dec),
    .stall_to_dec(stall_to_dec), .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
    .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
    .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
    .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
    .ready1_from_rob(ready1_from_rob), .ready2_from_rob(ready2_from_rob),
    .val1_from_rob(val1_from_rob), .val2_from_rob(val2_from_rob),
    .rob_id_from_rob(rob_id_from_rob), .full_from_rob(full_from_rob),
    .full_from_rs(full_from_rs), .full_from_lsb(full_from_lsb),
    .ena_to_rob(ena_to_rob), .ena_to_rs(ena_to_rs), .ena_to_lsb(ena_to_lsb),
    .openum_to_rs(openum_to_rs), .V1_to_rs(V1_to_rs), .V2_to_rs(V2_to_rs),
    .Q1_to_rs(Q1_to_rs), .Q2_to_rs(Q2_to_rs), .pc_to_rs(pc_to_rs),
    .imm_to_rs(imm_to_rs), .rob_id_to_rs(rob_id_to_rs),
    .openum_to_lsb(openum_to_lsb), .V1_to_lsb(V1_to_lsb), .V2_to_lsb(V2_to_lsb),
    .Q1_to_lsb(Q1_to_lsb), .Q2_to_lsb(Q2_to_lsb), .pc_to_lsb(pc_to_lsb),
    .imm_to_lsb(imm_to_lsb), .rob_id_to_lsb(rob_id_to_lsb), .rd_to_rob(rd_to_rob),
    .ena_rename_to_reg(ena_rename_to_reg), .rd_to_reg(rd_to_reg),
    .rob_id_to_reg(rob_id_to_reg),
    .valid_from_rs_cdb(valid_from_rs_cdb), .rob_id_from_rs_cdb(rob_id_from_rs_cdb),
    .result_from_rs_cdb(result_from_rs_cdb),
    .valid_from_ls_cdb(valid_from_ls_cdb), .rob_id_from_ls_cdb(rob_id_from_ls_cdb),
    .result_from_ls_cdb(result_from_ls_cdb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_issue(input logic [5:0] op, input logic [31:0] v1, input logic [4:0] q1,
                              input logic [31:0] v2, input logic [4:0] q2, input logic [31:0] imm,
                              input logic [31:0] pc, input logic [4:0] rob, input logic [4:0] rd,
                              input logic is_ls);
    exp_t e;
    e.op = op; e.v1 = v1; e.q1 = q1; e.v2 = v2; e.q2 = q2;
    e.imm = imm; e.pc = pc; e.rob = rob; e.rd = rd; e.is_ls = is_ls;
    sb.push_back(e);
  endtask

  task automatic offer(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                       input logic is_ls, input logic [31:0] v1, input logic [4:0] q1,
                       input logic [31:0] v2, input logic [4:0] q2);
    openum_from_dec = op; rd_from_dec = rd; rs1_from_dec = rs1; rs2_from_dec = rs2;
    imm_from_dec = imm; pc_from_dec = pc; is_ls_from_dec = is_ls;
    V1_from_reg = v1; Q1_from_reg = q1; V2_from_reg = v2; Q2_from_reg = q2;
    valid_from_dec = 1'b1;
  endtask

  // Holds valid until the instruction is taken at a posedge, then drops it.
  task automatic wait_accept();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!stall_to_dec) done = 1;
      @(posedge clk); #1;
    end
    valid_from_dec = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Issue monitor: every ROB strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (ena_to_rob) begin
        if (sb.size() == 0) begin
          check("unexpected_issue", 1, 0);
        end else begin
          r_exp = sb.pop_front();
          check("route_rs", ena_to_rs, !r_exp.is_ls);
          check("route_lsb", ena_to_lsb, r_exp.is_ls);
          check("rename_strobe", ena_rename_to_reg, r_exp.rd != 5'd0);
          check("openum", r_exp.is_ls ? openum_to_lsb : openum_to_rs, r_exp.op);
          check("V1", r_exp.is_ls ? V1_to_lsb : V1_to_rs, r_exp.v1);
          check("Q1", r_exp.is_ls ? Q1_to_lsb : Q1_to_rs, r_exp.q1);
          check("V2", r_exp.is_ls ? V2_to_lsb : V2_to_rs, r_exp.v2);
          check("Q2", r_exp.is_ls ? Q2_to_lsb : Q2_to_rs, r_exp.q2);
          check("imm", r_exp.is_ls ? imm_to_lsb : imm_to_rs, r_exp.imm);
          check("pc", r_exp.is_ls ? pc_to_lsb : pc_to_rs, r_exp.pc);
          check("rob_id", r_exp.is_ls ? rob_id_to_lsb : rob_id_to_rs, r_exp.rob);
          check("rd_to_rob", rd_to_rob, r_exp.rd);
          if (r_exp.rd != 5'd0) begin
            check("rd_to_reg", rd_to_reg, r_exp.rd);
            check("rob_id_to_reg", rob_id_to_reg, r_exp.rob);
          end
        end
      end else if (ena_to_rs || ena_to_lsb || ena_rename_to_reg) begin
        check("stray_strobe", 1, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; rollback = 1; valid_from_dec = 0;
    openum_from_dec = '0; rd_from_dec = '0; rs1_from_dec = '0; rs2_from_dec = '0;
    imm_from_dec = '0; pc_from_dec = '0; is_ls_from_dec = 0;
    V1_from_reg = '0; V2_from_reg = '0; Q1_from_reg = '0; Q2_from_reg = '0;
    ready1_from_rob = 0; ready2_from_rob = 0; val1_from_rob = '0; val2_from_rob = '0;
    rob_id_from_rob = 5'd1; full_from_rob = 0; full_from_rs = 0; full_from_lsb = 0;
    valid_from_rs_cdb = 0; rob_id_from_rs_cdb = '0; result_from_rs_cdb = '0;
    valid_from_ls_cdb = 0; rob_id_from_ls_cdb = '0; result_from_ls_cdb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0; rollback = 0;

    // Reset state
    @(negedge clk);
    check("rst_stall", stall_to_dec, 0);
    check("rst_ena_rob", ena_to_rob, 0);
    check("rst_ena_rs", ena_to_rs, 0);
    check("rst_ena_lsb", ena_to_lsb, 0);
    check("rst_rename", ena_rename_to_reg, 0);
    check("rst_openum_rs", openum_to_rs, OPENUM_NOP);
    check("rst_openum_lsb", openum_to_lsb, OPENUM_NOP);
    check("rst_V1", V1_to_rs, 0);
    check("rst_rob_id", rob_id_to_rs, 0);
    check("rst_rd_to_reg", rd_to_reg, 0);
    @(posedge clk); #1;

    // addi x5,x0,7
    rob_id_from_rob = 5'd3;
    expect_issue(OPENUM_ADDI, 32'h0, 5'd0, 32'h0, 5'd0, 32'd7, 32'h100, 5'd3, 5'd5, 1'b0);
    offer(OPENUM_ADDI, 5'd5, 5'd0, 5'd0, 32'd7, 32'h100, 1'b0, 32'h0, 5'd0, 32'h0, 5'd0);
    wait_accept();
    drain();

    // ROB-ready bypass; stale regfile value must be ignored
    rob_id_from_rob = 5'd4;
    ready1_from_rob = 1; val1_from_rob = 32'h55;
    expect_issue(OPENUM_ADD, 32'h55, 5'd0, 32'h9, 5'd0, 32'h0, 32'h104, 5'd4, 5'd6, 1'b0);
    offer(OPENUM_ADD, 5'd6, 5'd1, 5'd2, 32'h0, 32'h104, 1'b0, 32'hdead, 5'd2, 32'h9, 5'd0);
    #2;
    check("rs1_to_reg", rs1_to_reg, 5'd1);
    check("rs2_to_reg", rs2_to_reg, 5'd2);
    check("Q1_to_rob", Q1_to_rob, 5'd2);
    wait_accept();
    ready1_from_rob = 0; val1_from_rob = '0;
    drain();

    // Same-cycle CDB at accept, beating a ready ROB entry
    rob_id_from_rob = 5'd5;
    ready2_from_rob = 1; val2_from_rob = 32'h77;
    valid_from_rs_cdb = 1; rob_id_from_rs_cdb = 5'd4; result_from_rs_cdb = 32'hAB;
    expect_issue(OPENUM_XOR, 32'h11, 5'd0, 32'hAB, 5'd0, 32'h0, 32'h108, 5'd5, 5'd7, 1'b0);
    offer(OPENUM_XOR, 5'd7, 5'd3, 5'd4, 32'h0, 32'h108, 1'b0, 32'h11, 5'd0, 32'h0, 5'd4);
    wait_accept();
    valid_from_rs_cdb = 0; ready2_from_rob = 0; val2_from_rob = '0;
    drain();

    // Stall with snoop on both CDBs; next op accepted on the issue edge
    rob_id_from_rob = 5'd6;
    full_from_rs = 1;
    expect_issue(OPENUM_AND, 32'h10, 5'd0, 32'h20, 5'd0, 32'h0, 32'h10c, 5'd10, 5'd8, 1'b0);
    offer(OPENUM_AND, 5'd8, 5'd1, 5'd2, 32'h0, 32'h10c, 1'b0, 32'h0, 5'd6, 32'h0, 5'd9);
    wait_accept();
    expect_issue(OPENUM_OR, 32'h3, 5'd0, 32'h4, 5'd0, 32'h0, 32'h110, 5'd10, 5'd9, 1'b0);
    offer(OPENUM_OR, 5'd9, 5'd3, 5'd4, 32'h0, 32'h110, 1'b0, 32'h3, 5'd0, 32'h4, 5'd0);
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) rob_id_from_rob = 5'd10;
      if (k == 3) begin
        valid_from_ls_cdb = 1; rob_id_from_ls_cdb = 5'd6; result_from_ls_cdb = 32'h10;
        valid_from_rs_cdb = 1; rob_id_from_rs_cdb = 5'd9; result_from_rs_cdb = 32'h20;
      end
      @(negedge clk);
      check("stall_held", stall_to_dec, 1);
      @(posedge clk); #1;
      valid_from_ls_cdb = 0; valid_from_rs_cdb = 0;
    end
    full_from_rs = 0;
    #2;
    check("same_edge_accept", stall_to_dec, 0);
    wait_accept();
    drain();

    // Load to LSB with rd=x0 while RS is full
    rob_id_from_rob = 5'd11;
    full_from_rs = 1;
    expect_issue(OPENUM_LW, 32'h1000, 5'd0, 32'h0, 5'd0, 32'd4, 32'h114, 5'd11, 5'd0, 1'b1);
    offer(OPENUM_LW, 5'd0, 5'd2, 5'd0, 32'd4, 32'h114, 1'b1, 32'h1000, 5'd0, 32'h0, 5'd0);
    wait_accept();
    drain();
    full_from_rs = 0;

    // Back-to-back throughput
    rob_id_from_rob = 5'd12;
    for (int k = 0; k < 3; k++) begin
      expect_issue(OPENUM_ADDI, 32'h0, 5'd0, 32'h0, 5'd0, 32'(k + 1), 32'(32'h118 + 4 * k),
                   5'd12, 5'(10 + k), 1'b0);
      offer(OPENUM_ADDI, 5'(10 + k), 5'd0, 5'd0, 32'(k + 1), 32'(32'h118 + 4 * k), 1'b0,
            32'h0, 5'd0, 32'h0, 5'd0);
      #2;
      check("burst_no_stall", stall_to_dec, 0);
      @(posedge clk); #1;
    end
    valid_from_dec = 0;
    drain();

    // Rollback while stalled on a full ROB: flushed op must never issue
    rob_id_from_rob = 5'd13;
    full_from_rob = 1;
    offer(OPENUM_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 32'h124, 1'b0, 32'h1, 5'd0, 32'h2, 5'd0);
    wait_accept();
    #2;
    check("stall_before_rollback", stall_to_dec, 1);
    @(posedge clk); #1 rollback = 1;
    @(posedge clk); #1 rollback = 0;
    #2;
    check("rollback_clears_busy", stall_to_dec, 0);
    full_from_rob = 0;
    repeat (5) @(posedge clk);
    #1;
    expect_issue(OPENUM_ADDI, 32'h0, 5'd0, 32'h0, 5'd0, 32'd9, 32'h128, 5'd13, 5'd4, 1'b0);
    offer(OPENUM_ADDI, 5'd4, 5'd0, 5'd0, 32'd9, 32'h128, 1'b0, 32'h0, 5'd0, 32'h0, 5'd0);
    wait_accept();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
